// File: rtl/zap_copro_responder_pkg.sv
// Shared definitions for the coprocessor responder: FSM states, instruction
// field positions, processor mode constants and coprocessor register indices.
package zap_copro_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } state_t;

    localparam int          OPC_HI      = 27;
    localparam int          OPC_LO      = 24;
    localparam logic [3:0]  OPC_CPREG   = 4'b1110;
    localparam int          BIT_REGXFER = 4;
    localparam int          BIT_L       = 20;
    localparam int          CRN_HI      = 19;
    localparam int          CRN_LO      = 16;
    localparam int          CPN_HI      = 11;
    localparam int          CPN_LO      = 8;
    localparam logic [4:0]  MODE_USR    = 5'b10000;
    localparam logic [3:0]  CR_ID       = 4'd0;
    localparam logic [3:0]  CR_CTRL     = 4'd1;

    // MCR/MRC register transfer aimed at this coprocessor number.
    function automatic logic is_reg_xfer(input logic [31:0] word, input logic [3:0] cp_num);
        return (word[OPC_HI:OPC_LO] == OPC_CPREG) && word[BIT_REGXFER] &&
               (word[CPN_HI:CPN_LO] == cp_num);
    endfunction

endpackage

// File: rtl/zap_copro_responder_regbank.sv
// 16x32 coprocessor register bank: c0 holds the read-only ID, c1 is exported
// as the live system control word.
module zap_copro_regbank #(
    parameter logic [31:0] CP_ID      = 32'h4100_0000,
    parameter logic [31:0] CTRL_RESET = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en_i,
    input  logic [3:0]  i_wr_idx_i,
    input  logic [31:0] i_wr_data_i,
    input  logic [3:0]  i_rd_idx_i,
    output logic [31:0] o_rd_data_o,
    output logic [31:0] o_ctrl_o
);
    import zap_copro_responder_pkg::*;

    logic [31:0] regs_q [16];

    // Bank storage; writes to c0 are dropped so it always reads back the ID.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
            regs_q[CR_ID]   <= CP_ID;
            regs_q[CR_CTRL] <= CTRL_RESET;
        end else if (i_wr_en_i && (i_wr_idx_i != CR_ID)) begin
            regs_q[i_wr_idx_i] <= i_wr_data_i;
        end
    end

    assign o_rd_data_o = regs_q[i_rd_idx_i];
    assign o_ctrl_o    = regs_q[CR_CTRL];

endmodule

// File: rtl/zap_copro_responder.sv
// Coprocessor-side handshake responder executing MCR/MRC against a local bank.
// Optional macro ZAP_COPRO_PRIV_CHECK_EN rejects accepted instructions from USR mode.
module zap_copro_responder #(
    parameter int          PHY_REGS   = 46,
    parameter int          CP_NUM     = 15,
    parameter logic [31:0] CP_ID      = 32'h4100_0000,
    parameter logic [31:0] CTRL_RESET = 32'd0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_copro_dav,
    input  logic [31:0]                 i_copro_word,
    input  logic [$clog2(PHY_REGS)-1:0] i_copro_reg,
    input  logic [31:0]                 i_cpsr,
    output logic                        o_copro_done,
    output logic                        o_und,
    output logic                        o_reg_en,
    output logic                        o_reg_wr,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_index,
    output logic [31:0]                 o_reg_wr_data,
    input  logic [31:0]                 i_reg_rd_data,
    output logic [31:0]                 o_cp_ctrl
);
    import zap_copro_responder_pkg::*;

    localparam int         IDX_W    = $clog2(PHY_REGS);
    localparam logic [3:0] CP_NUM_L = CP_NUM[3:0];

    state_t             state_q, state_d;
    logic [3:0]         crn_q, crn_s;
    logic               rej_q;
    logic               accept_s, priv_fail_s, und_s;
    logic [31:0]        bank_rd_s;
    logic               done_q, done_d, und_q, und_d;
    logic               reg_en_q, reg_en_d, reg_wr_q, reg_wr_d;
    logic [IDX_W-1:0]   reg_index_q, reg_index_d;
    logic [31:0]        reg_wr_data_q, reg_wr_data_d;
    logic               unused_s;

`ifdef ZAP_COPRO_PRIV_CHECK_EN
    assign priv_fail_s = (i_cpsr[4:0] == MODE_USR);
`else
    assign priv_fail_s = 1'b0;
`endif
    assign unused_s = ^{i_copro_word[31:28], i_copro_word[23:21], i_copro_word[15:12],
                        i_copro_word[7:5], i_copro_word[3:0], i_cpsr};

    assign accept_s = is_reg_xfer(i_copro_word, CP_NUM_L) && !priv_fail_s;
    // In IDLE the instruction fields are taken live; afterwards from the latched copy.
    assign crn_s    = (state_q == ST_IDLE) ? i_copro_word[CRN_HI:CRN_LO] : crn_q;
    assign und_s    = (state_q == ST_IDLE) ? !accept_s : rej_q;

    zap_copro_regbank #(
        .CP_ID      (CP_ID),
        .CTRL_RESET (CTRL_RESET)
    ) u_bank (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_en_i   (state_q == ST_RD_DATA),
        .i_wr_idx_i  (crn_q),
        .i_wr_data_i (i_reg_rd_data),
        .i_rd_idx_i  (crn_s),
        .o_rd_data_o (bank_rd_s),
        .o_ctrl_o    (o_cp_ctrl)
    );

    // State register and instruction latch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            crn_q   <= 4'd0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && i_copro_dav) begin
                crn_q <= i_copro_word[CRN_HI:CRN_LO];
                rej_q <= !accept_s;
            end else begin
                crn_q <= crn_q;
                rej_q <= rej_q;
            end
        end
    end

    // Next-state logic; a dropped dav before DONE is a pipeline flush.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (!i_copro_dav)               state_d = ST_IDLE;
                else if (!accept_s)             state_d = ST_DONE;
                else if (i_copro_word[BIT_L])   state_d = ST_WR;
                else                            state_d = ST_RD_REQ;
            end
            ST_RD_REQ:   state_d = i_copro_dav ? ST_RD_DATA  : ST_IDLE;
            ST_RD_DATA:  state_d = i_copro_dav ? ST_DONE     : ST_IDLE;
            ST_WR:       state_d = i_copro_dav ? ST_DONE     : ST_IDLE;
            ST_DONE:     state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: state_d = i_copro_dav ? ST_WAIT_LOW : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs are registered with it.
    always_comb begin
        reg_en_d      = (state_d == ST_RD_REQ) || (state_d == ST_WR);
        reg_wr_d      = (state_d == ST_WR);
        reg_index_d   = reg_en_d ? i_copro_reg : {IDX_W{1'b0}};
        reg_wr_data_d = (state_d == ST_WR) ? bank_rd_s : 32'd0;
        done_d        = (state_d == ST_DONE);
        und_d         = (state_d == ST_DONE) && und_s;
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            done_q        <= 1'b0;
            und_q         <= 1'b0;
            reg_en_q      <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_index_q   <= {IDX_W{1'b0}};
            reg_wr_data_q <= 32'd0;
        end else begin
            done_q        <= done_d;
            und_q         <= und_d;
            reg_en_q      <= reg_en_d;
            reg_wr_q      <= reg_wr_d;
            reg_index_q   <= reg_index_d;
            reg_wr_data_q <= reg_wr_data_d;
        end
    end

    assign o_copro_done  = done_q;
    assign o_und         = und_q;
    assign o_reg_en      = reg_en_q;
    assign o_reg_wr      = reg_wr_q;
    assign o_reg_index   = reg_index_q;
    assign o_reg_wr_data = reg_wr_data_q;

endmodule
